// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider returning {remainder, quotient}, signed or unsigned.
// Optional `DIV_FAST_PATH_EN: early exit for divide-by-zero and |dividend| < |divisor|.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               is_signed_i,
    input  logic               cancel_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 qNeg_q, qNeg_d;
    logic                 rNeg_q, rNeg_d;
    logic                 dvsZero_q, dvsZero_d;
    logic                 fast_q, fast_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 divByZero_q, divByZero_d;

    logic [WIDTH-1:0]     ddMag, dvMag;
    logic                 fastStart;
    logic [WIDTH:0]       shifted, diff, remNext;
    logic                 qBit;
    logic [WIDTH-1:0]     quoNext, quoRaw, remRaw, quoFin, remFin;

    assign ddMag = (is_signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign dvMag = (is_signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

`ifdef DIV_FAST_PATH_EN
    assign fastStart = (divisor_i == '0) || (ddMag < dvMag);
`else
    assign fastStart = 1'b0;
`endif

    // quo_q starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in.
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        qBit    = ~diff[WIDTH];
        remNext = qBit ? diff : shifted;
        quoNext = {quo_q[WIDTH-2:0], qBit};
        quoRaw  = fast_q ? '0 : quoNext;
        remRaw  = fast_q ? quo_q : remNext[WIDTH-1:0];
        quoFin  = dvsZero_q ? '1 : (qNeg_q ? -quoRaw : quoRaw);
        remFin  = rNeg_q ? -remRaw : remRaw;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qNeg_d      = qNeg_q;
        rNeg_d      = rNeg_q;
        dvsZero_d   = dvsZero_q;
        fast_d      = fast_q;
        result_d    = result_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = CALC;
                    count_d   = '0;
                    rem_d     = '0;
                    quo_d     = ddMag;
                    dvs_d     = dvMag;
                    qNeg_d    = is_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    rNeg_d    = is_signed_i & dividend_i[WIDTH-1];
                    dvsZero_d = (divisor_i == '0);
                    fast_d    = fastStart;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d   = remNext;
                quo_d   = quoNext;
                count_d = count_q + CW'(1);
                if (fast_q || count_q == LAST) begin
                    state_d     = DONE;
                    result_d    = {remFin, quoFin};
                    divByZero_d = dvsZero_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // An abort must not disturb the previously reported result.
        if (cancel_i) begin
            state_d     = IDLE;
            count_d     = '0;
            result_d    = result_q;
            divByZero_d = divByZero_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
            dvsZero_q   <= 1'b0;
            fast_q      <= 1'b0;
            result_q    <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            qNeg_q      <= qNeg_d;
            rNeg_q      <= rNeg_d;
            dvsZero_q   <= dvsZero_d;
            fast_q      <= fast_d;
            result_q    <= result_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign busy_o        = (state_q == CALC);
    assign done_o        = (state_q == DONE);
    assign result_o      = result_q;
    assign div_by_zero_o = divByZero_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit (WIDTH=32): directed cases plus random operands vs. an arithmetic model.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        isSigned;
    logic        cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        divByZero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .is_signed_i   (isSigned),
        .cancel_i      (cancel),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .div_by_zero_o (divByZero)
    );

    // Reference: {flag, remainder, quotient} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic longint magnitude(input logic [31:0] x, input logic sgn);
        if (sgn && x[31]) return -longint'($signed(x));
        return longint'({32'd0, x});
    endfunction

    function automatic int expLatency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_FAST_PATH_EN
        if (b == 32'd0 || magnitude(a, sgn) < magnitude(b, sgn)) return 2;
`else
        if (magnitude(a, sgn) < 0) return 0;
`endif
        return 33;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound expires)
    task automatic applyStimulus(input logic [31:0] dd, input logic [31:0] dv, input logic sgn,
                                 output int cycles, output logic busyOk);
        dividend = dd;
        divisor  = dv;
        isSigned = sgn;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        busyOk = 1'b1;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (busy !== 1'b0) busyOk = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                               input logic sgn, input int cycles, input logic busyOk);
        logic [64:0] exp;
        exp = model(dd, dv, sgn);
        checkValue({tag, " latency"}, 64'(cycles), 64'(expLatency(dd, dv, sgn)));
        checkValue({tag, " busy"}, {63'd0, busyOk}, 64'd1);
        checkValue({tag, " result"}, result, exp[63:0]);
        checkValue({tag, " dbz"}, {63'd0, divByZero}, {63'd0, exp[64]});
    endtask

    task automatic runAndCheck(input string tag, input logic [31:0] dd, input logic [31:0] dv, input logic sgn);
        int   cyc;
        logic bOk;
        applyStimulus(dd, dv, sgn, cyc, bOk);
        checkOutput(tag, dd, dv, sgn, cyc, bOk);
    endtask

    initial begin
        logic [63:0] held;
        logic        sawDone;
        logic [31:0] rdd, rdv;
        logic        rsg;
        int          cyc;
        logic        bOk;

        rst = 1'b1; start = 1'b0; isSigned = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        #1;
        checkValue("reset result", result, 64'd0);
        checkValue("reset flags", {61'd0, busy, done, divByZero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runAndCheck("100/7 u", 32'd100, 32'd7, 1'b0);
        checkValue("100/7 value", result, {32'h00000002, 32'h0000000E});
        @(negedge clk);
        checkValue("done one cycle", {62'd0, done, busy}, 64'd0);

        runAndCheck("-7/2 s", 32'hFFFFFFF9, 32'd2, 1'b1);
        checkValue("-7/2 value", result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        runAndCheck("7/-2 s", 32'd7, 32'hFFFFFFFE, 1'b1);
        checkValue("7/-2 value", result, {32'h00000001, 32'hFFFFFFFD});
        runAndCheck("min/-1 s", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        checkValue("min/-1 value", result, {32'h00000000, 32'h80000000});
        runAndCheck("5/0 u", 32'd5, 32'd0, 1'b0);
        checkValue("5/0 value", {result, 63'd0, divByZero} >> 64, result);
        checkValue("5/0 flag", {63'd0, divByZero}, 64'd1);
        runAndCheck("-9/0 s", 32'hFFFFFFF7, 32'd0, 1'b1);
        runAndCheck("3/10 u", 32'd3, 32'd10, 1'b0);
        runAndCheck("10/3 u", 32'd10, 32'd3, 1'b0);
        @(negedge clk);

        // Cancel a second divide at cycle 10; the first result must survive.
        runAndCheck("pre-cancel", 32'd1000, 32'd9, 1'b0);
        held = result;
        @(negedge clk);
        dividend = 32'd55555; divisor = 32'd7; isSigned = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkValue("cancel busy", {63'd0, busy}, 64'd0);
        sawDone = 1'b0;
        repeat (40) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkValue("cancel no done", {63'd0, sawDone}, 64'd0);
        checkValue("cancel held", result, held);
        runAndCheck("9/3 after cancel", 32'd9, 32'd3, 1'b0);
        checkValue("9/3 value", result, {32'd0, 32'd3});
        @(negedge clk);

        // Simultaneous start and cancel: cancel wins.
        dividend = 32'd77; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checkValue("start+cancel busy", {63'd0, busy}, 64'd0);
        @(negedge clk);

        // A start pulse during CALC is ignored.
        dividend = 32'd100; divisor = 32'd7; isSigned = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        checkValue("ignore start latency", 64'(cyc), 64'd33);
        checkValue("ignore start result", result, {32'd2, 32'd14});
        @(negedge clk);
        checkValue("ignore start no requeue", {62'd0, busy, done}, 64'd0);

        // Asynchronous reset in the middle of CALC.
        dividend = 32'd12345; divisor = 32'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkValue("async reset result", result, 64'd0);
        checkValue("async reset flags", {61'd0, busy, done, divByZero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle of the first.
        runAndCheck("b2b first", 32'd500, 32'd13, 1'b0);
        runAndCheck("b2b second", 32'hFFFFFC00, 32'd3, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rsg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin rdd = $urandom; rdv = $urandom; end
                1: begin rdd = $urandom; rdv = $urandom_range(1, 300); end
                2: begin rdd = $urandom_range(0, 50); rdv = $urandom; end
                3: begin rdd = $urandom; rdv = 32'd0; end
                default: begin rdd = 32'h80000000; rdv = 32'hFFFFFFFF; rsg = 1'b1; end
            endcase
            applyStimulus(rdd, rdv, rsg, cyc, bOk);
            checkOutput($sformatf("rand%0d", i), rdd, rdv, rsg, cyc, bOk);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
